// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port between producers A and B, bursts of up to BURST_MAX beats.
// Latency: grant 1 cycle after valid while idle; zero-bubble handover at burst end; ready/wr_en are combinational.
// Backpressure: fifo_full combinationally drops the owner's ready and wr_en; grant, beat count and totals hold while full.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [1:0]        grant,
  output logic [15:0]       beats_a,
  output logic [15:0]       beats_b
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

  state_t      state_q, state_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        last_q, last_d;          // last released owner: 0 = A, 1 = B
  logic [15:0] beats_a_q, beats_a_d;
  logic [15:0] beats_b_q, beats_b_d;

  logic own_a, own_b;
  logic xfer_a, xfer_b;

  // Handshake and write-port outputs, decoded straight from the owner and fifo_full.
  always_comb begin
    own_a        = (state_q == OWN_A);
    own_b        = (state_q == OWN_B);
    a_ready      = own_a & ~fifo_full;
    b_ready      = own_b & ~fifo_full;
    xfer_a       = a_ready & a_valid;
    xfer_b       = b_ready & b_valid;
    fifo_wr_en   = xfer_a | xfer_b;
    fifo_wr_data = own_a ? a_data : (own_b ? b_data : '0);
    grant        = state_q;
    beats_a      = beats_a_q;
    beats_b      = beats_b_q;
  end

  // Next owner, burst position and accepted-beat totals.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    beats_a_d  = beats_a_q + {15'd0, xfer_a};
    beats_b_d  = beats_b_q + {15'd0, xfer_b};
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (a_valid && b_valid) state_d = last_q ? OWN_A : OWN_B;
        else if (a_valid)       state_d = OWN_A;
        else if (b_valid)       state_d = OWN_B;
      end
      OWN_A: begin
        if (!a_valid || (xfer_a && beat_cnt_q == CNT_LAST)) begin
          // Release: the other side has priority; a still-valid owner is
          // re-granted only after a full burst (a_valid is low on a drop).
          last_d     = 1'b0;
          beat_cnt_d = '0;
          if (b_valid)      state_d = OWN_B;
          else if (a_valid) state_d = OWN_A;
          else              state_d = IDLE;
        end else if (xfer_a) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      OWN_B: begin
        if (!b_valid || (xfer_b && beat_cnt_q == CNT_LAST)) begin
          last_d     = 1'b1;
          beat_cnt_d = '0;
          if (a_valid)      state_d = OWN_A;
          else if (b_valid) state_d = OWN_B;
          else              state_d = IDLE;
        end else if (xfer_b) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset leaves B as last owner so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      last_q     <= 1'b1;
      beats_a_q  <= '0;
      beats_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      beats_a_q  <= beats_a_d;
      beats_b_q  <= beats_b_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that lets two producers (A and B) share the single write port of the team's synchronous FIFO (`fifo2`). Each producer uses a valid/ready handshake. The arbiter grants the FIFO to one producer at a time in bursts of up to `BURST_MAX` beats and back-pressures the owner while the FIFO reports full. It also keeps a per-producer count of accepted beats for debug.

## Interface
Parameters:
- `DATA_W`, default 8: width of the data paths; matches the FIFO `write_data` width.
- `BURST_MAX`, default 4: maximum beats per grant, legal range 1..16.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `a_valid`, in, 1: producer A has a beat on `a_data`.
- `a_data`, in, `DATA_W`: producer A payload.
- `a_ready`, out, 1: producer A's beat is accepted this cycle.
- `b_valid`, in, 1: producer B has a beat on `b_data`.
- `b_data`, in, `DATA_W`: producer B payload.
- `b_ready`, out, 1: producer B's beat is accepted this cycle.
- `fifo_full`, in, 1: FIFO `full` flag.
- `fifo_wr_en`, out, 1: drives FIFO `write_enable`.
- `fifo_wr_data`, out, `DATA_W`: drives FIFO `write_data`.
- `grant`, out, 2: one-hot current owner; bit0 = A, bit1 = B, 00 = none.
- `beats_a`, out, 16: beats accepted from A; wraps 0xFFFF -> 0.
- `beats_b`, out, 16: beats accepted from B; wraps 0xFFFF -> 0.

## Operation
- **States:** IDLE, OWN_A, OWN_B. Registered state comprises:
  - the state itself,
  - `beat_cnt` (0..`BURST_MAX`-1),
  - `last` (last released owner),
  - `beats_a` and `beats_b`.
- **Combinational outputs:**
  - `a_ready` = OWN_A & !`fifo_full`; `b_ready` = OWN_B & !`fifo_full`.
  - `fifo_wr_en` = (OWN_A & `a_valid` | OWN_B & `b_valid`) & !`fifo_full`.
  - `fifo_wr_data` = owner's data; 0 in IDLE.
  - `grant` decodes the state.
- **Transfer:** occurs on the edge where the owner's valid & ready are both high. The FIFO samples the same edge.
- **IDLE:**
  - Neither valid: stay in IDLE.
  - One valid: go to that producer's OWN state.
  - Both valid: grant the producer that is not `last`.
  - `beat_cnt` is set to 0 on entry to any OWN state.
- **OWN_X, owner valid high and `fifo_full` high:** hold state, `beat_cnt` and counters.
- **OWN_X, transfer with `beat_cnt` < `BURST_MAX`-1:** `beat_cnt` increments; stay in OWN_X.
- **OWN_X, transfer with `beat_cnt` = `BURST_MAX`-1 (burst end):** release the grant.
- **OWN_X, owner valid low:** release the grant, regardless of `fifo_full`. No transfer happens that cycle.
- **Release:**
  - `last` := X.
  - If the other producer's valid is high, go to OWN_other.
  - Else, if this was a burst end and X's valid is still high, re-grant OWN_X (counter reset).
  - Else, go to IDLE.
- **Counters:** `beats_a` / `beats_b` increment by 1 on each transfer from that producer, modulo 2^16.
- **Producer protocol:** data must be stable while valid is high and ready is low. A producer may drop valid at any time; the arbiter treats a drop as end of burst.

## Timing
- **Reset** (`rst` high at an edge):
  - State goes to IDLE; `beat_cnt` = 0; `last` = B, so A wins the first tie.
  - `beats_a` = `beats_b` = 0.
  - Outputs the following cycle: `a_ready` = `b_ready` = `fifo_wr_en` = 0, `fifo_wr_data` = 0, `grant` = 00.
  - Reset mid-burst aborts the burst with no further writes.
- **Grant latency from IDLE:** 1 cycle. Valid rises before edge N, and ready/`fifo_wr_en` are high in the cycle after edge N.
- **Owner-to-owner handover:** zero bubble cycles on a burst end, including a re-grant to the same producer.
- **Handover after a valid drop:** one idle-bus cycle (the cycle in which valid was low).
- **Full to write latency:** 0 cycles, combinational. `fifo_full` rising blocks a write in the same cycle; `fifo_full` falling permits one in the same cycle.
- **Throughput:** one beat per cycle while the FIFO is not full.
- **Worst-case wait:** a producer waits at most `BURST_MAX` transfers of the other producer once its valid is high.

## Test plan
- **Reset:** hold `rst` high for 2 cycles with both valids high. Required: all outputs 0 and `grant` = 00 while in reset. In the first cycle after release, `grant` = 00; in the next cycle, `grant` = 01.
- **A alone:** A presents data 0x01..0x06 continuously, `BURST_MAX` = 4, FIFO not full. Required:
  - six consecutive writes 0x01..0x06 starting one cycle after valid;
  - no gap at the 4-to-5 boundary;
  - `beats_a` = 6 and `beats_b` = 0 at the end.
- **Contention:** A presents 0x10..0x17 and B presents 0x20..0x27, both continuous. Required write order: 0x10-13, 0x20-23, 0x14-17, 0x24-27, with no idle cycles after the first write.
- **Full stall:** during an A burst, `fifo_full` is high for 3 cycles after the 2nd beat. Required:
  - `fifo_wr_en` = 0 and `a_ready` = 0 for those 3 cycles;
  - `beat_cnt` holds;
  - beats 3 and 4 are written when full drops, then the grant moves to B if B is valid.
- **Valid drop:** A drops valid after 2 beats while B is valid. Required: one cycle with `fifo_wr_en` = 0, then `grant` = 10 and B's data is written.
- **Counter wrap and mid-burst reset:** preload `beats_b` near 0xFFFF via a long B stream. Required: after 0xFFFF the next transfer gives 0. Then assert `rst` mid-burst. Required: the next cycle shows all-zero outputs, and A wins the following tie.
